trap_controller: RTL and testbench

//   Sequences trap entry and MRET for the machine-mode CSR unit. At each instruction

---
 rtl/trap_controller_pkg.sv | 39 +++
 rtl/trap_controller_exc_prio_enc.sv | 35 +++
 rtl/trap_controller.sv | 132 +++++++++++++
 tb/tb_trap_controller.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_controller_pkg.sv
// -----------------------------------------------------------------------------
// trap_controller_pkg
//   Shared definitions for the machine-mode trap sequencer: exception request
//   bit positions, mcause exception codes, the sequencer state encoding and the
//   result record of the exception priority encoder.
// -----------------------------------------------------------------------------
package trap_controller_pkg;

    // Bit positions inside exc_req.
    localparam int EXC_IF_MISALIGN = 0;
    localparam int EXC_ILLEGAL     = 1;
    localparam int EXC_EBREAK      = 2;
    localparam int EXC_ECALL       = 3;
    localparam int EXC_LD_MISALIGN = 4;
    localparam int EXC_ST_MISALIGN = 5;

    // mcause exception codes (interrupt bit clear).
    localparam logic [3:0] CAUSE_IF_MISALIGN = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
    localparam logic [3:0] CAUSE_EBREAK      = 4'd3;
    localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
    localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_ECALL       = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ENTER    = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_RETURN   = 2'd3
    } state_t;

    // Winning exception: use_tval selects exc_tval for mtval, otherwise zero.
    typedef struct packed {
        logic       valid;
        logic [3:0] cause;
        logic       use_tval;
    } exc_sel_t;

endpackage

// File: rtl/trap_controller_exc_prio_enc.sv
// -----------------------------------------------------------------------------
// trap_controller_exc_prio_enc
//   Combinational priority encoder over the six synchronous exception requests.
//   Priority: if_misalign > illegal > ebreak > ecall > ld_misalign > st_misalign.
// Ports
//   exc_req  in   6   {st_misalign,ld_misalign,ecall,ebreak,illegal,if_misalign}
//   sel      out  -   {valid, cause[3:0], use_tval} of the highest-priority request
// -----------------------------------------------------------------------------
module trap_controller_exc_prio_enc
    import trap_controller_pkg::*;
(
    input  logic [5:0] exc_req,
    output exc_sel_t   sel
);

    // NOTE: every output of a combinational block gets a default on entry so
    // no path through the if/else chain leaves it unassigned (no latch).
    always_comb begin
        sel = '0;
        if (exc_req[EXC_IF_MISALIGN]) begin
            sel = '{valid: 1'b1, cause: CAUSE_IF_MISALIGN, use_tval: 1'b1};
        end else if (exc_req[EXC_ILLEGAL]) begin
            sel = '{valid: 1'b1, cause: CAUSE_ILLEGAL, use_tval: 1'b1};
        end else if (exc_req[EXC_EBREAK]) begin
            sel = '{valid: 1'b1, cause: CAUSE_EBREAK, use_tval: 1'b0};
        end else if (exc_req[EXC_ECALL]) begin
            sel = '{valid: 1'b1, cause: CAUSE_ECALL, use_tval: 1'b0};
        end else if (exc_req[EXC_LD_MISALIGN]) begin
            sel = '{valid: 1'b1, cause: CAUSE_LD_MISALIGN, use_tval: 1'b1};
        end else if (exc_req[EXC_ST_MISALIGN]) begin
            sel = '{valid: 1'b1, cause: CAUSE_ST_MISALIGN, use_tval: 1'b1};
        end
    end

endmodule

// File: rtl/trap_controller.sv
// -----------------------------------------------------------------------------
// trap_controller
//   Sequences machine-mode trap entry and MRET. At an instruction boundary in
//   IDLE it arbitrates interrupt > exception > MRET, flushes the instruction,
//   captures pc/cause/tval, then pulses trap_entry (and redirects to the trap
//   vector a cycle later) or pulses trap_return together with a redirect to mepc.
// Ports
//   clk, rst_n                         clock, asynchronous active-low reset
//   instr_boundary, cur_pc             committing instruction and its PC
//   exc_req, exc_tval                  exception requests and fault value
//   mret_req                           committing instruction is MRET
//   irq_pending_i, irq_cause_i         MIE-gated interrupt and its mcause
//   trap_vector_i, epc_i               CSR mtvec target (from trap_cause_o), mepc
//   trap_entry_o, trap_return_o        one-cycle pulses to the CSR unit
//   trap_pc_o/cause_o/val_o            registered mepc/mcause/mtval values
//   stall_o, flush_o                   core hold / kill of the instruction at cur_pc
//   redirect_valid_o, redirect_pc_o    fetch redirect
// -----------------------------------------------------------------------------
module trap_controller
    import trap_controller_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter bit IRQ_ENABLE = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_boundary,
    input  logic [XLEN-1:0] cur_pc,
    input  logic [5:0]      exc_req,
    input  logic [XLEN-1:0] exc_tval,
    input  logic            mret_req,
    input  logic            irq_pending_i,
    input  logic [XLEN-1:0] irq_cause_i,
    input  logic [XLEN-1:0] trap_vector_i,
    input  logic [XLEN-1:0] epc_i,
    output logic            trap_entry_o,
    output logic            trap_return_o,
    output logic [XLEN-1:0] trap_pc_o,
    output logic [XLEN-1:0] trap_cause_o,
    output logic [XLEN-1:0] trap_val_o,
    output logic            stall_o,
    output logic            flush_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o
);

    state_t          state_q, state_d;
    exc_sel_t        exc_sel;
    logic            irq_taken;
    logic            take_trap;
    logic            accept;
    logic [XLEN-1:0] pc_q, cause_q, val_q;

    trap_controller_exc_prio_enc u_exc_prio_enc (
        .exc_req (exc_req),
        .sel     (exc_sel)
    );

    assign irq_taken = IRQ_ENABLE && irq_pending_i;
    assign take_trap = irq_taken || exc_sel.valid;
    // Requests are only looked at in IDLE; during a sequence they are ignored.
    assign accept    = (state_q == ST_IDLE) && instr_boundary && (take_trap || mret_req);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            cause_q <= '0;
            val_q   <= '0;
        end else begin
            state_q <= state_d;
            // An interrupt pre-empts a coincident exception or MRET; that
            // instruction is flushed and re-executes after the handler returns.
            if (accept && take_trap) begin
                pc_q <= cur_pc;
                if (irq_taken) begin
                    cause_q <= irq_cause_i;
                    val_q   <= '0;
                end else begin
                    cause_q <= {{(XLEN-4){1'b0}}, exc_sel.cause};
                    val_q   <= exc_sel.use_tval ? exc_tval : '0;
                end
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        flush_o          = 1'b0;
        trap_entry_o     = 1'b0;
        trap_return_o    = 1'b0;
        stall_o          = 1'b0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    flush_o = 1'b1;
                    state_d = take_trap ? ST_ENTER : ST_RETURN;
                end
            end
            ST_ENTER: begin
                trap_entry_o = 1'b1;
                stall_o      = 1'b1;
                state_d      = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                // trap_cause_o is still held here, so a vectored mtvec target
                // computed from it by the CSR unit is valid this cycle.
                redirect_valid_o = 1'b1;
                redirect_pc_o    = trap_vector_i;
                stall_o          = 1'b1;
                state_d          = ST_IDLE;
            end
            ST_RETURN: begin
                trap_return_o    = 1'b1;
                redirect_valid_o = 1'b1;
                redirect_pc_o    = epc_i;
                stall_o          = 1'b1;
                state_d          = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign trap_pc_o    = pc_q;
    assign trap_cause_o = cause_q;
    assign trap_val_o   = val_q;

endmodule

// File: tb/tb_trap_controller.sv
// -----------------------------------------------------------------------------
// tb_trap_controller
//   Scoreboard bench for trap_controller. A driver issues boundary stimulus and
//   pushes the predicted trap/return into a queue; a monitor pops and compares
//   whenever the DUT pulses trap_entry/trap_return/redirect. A small CSR model
//   supplies mtvec-derived trap_vector_i and mepc.
// -----------------------------------------------------------------------------
module tb_trap_controller;

    localparam int XLEN = 32;

    typedef enum {K_ENTRY, K_RETURN} kind_t;
    typedef struct {
        kind_t       kind;
        int          cyc;
        logic [31:0] pc;
        logic [31:0] cause;
        logic [31:0] val;
        logic [31:0] redir;
    } exp_t;

    // Exception table indexed by exc_req bit; lower index = higher priority.
    localparam int unsigned EXC_CAUSE[6]    = '{0, 2, 3, 11, 4, 6};
    localparam bit          EXC_HAS_TVAL[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            instr_boundary = 1'b0;
    logic [XLEN-1:0] cur_pc = '0;
    logic [5:0]      exc_req = '0;
    logic [XLEN-1:0] exc_tval = '0;
    logic            mret_req = 1'b0;
    logic            irq_pending_i = 1'b0;
    logic [XLEN-1:0] irq_cause_i = '0;
    logic [XLEN-1:0] trap_vector_i;
    logic [XLEN-1:0] epc_i = '0;
    logic [XLEN-1:0] mtvec = '0;
    logic            trap_entry_o, trap_return_o, stall_o, flush_o, redirect_valid_o;
    logic [XLEN-1:0] trap_pc_o, trap_cause_o, trap_val_o, redirect_pc_o;

    int   cyc = 0;
    int   busy_until = -1;
    int   last_accept = -1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t pend;
    bit   pend_valid = 1'b0;
    exp_t mon_it;

    trap_controller #(.XLEN(XLEN), .IRQ_ENABLE(1'b1)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .instr_boundary   (instr_boundary),
        .cur_pc           (cur_pc),
        .exc_req          (exc_req),
        .exc_tval         (exc_tval),
        .mret_req         (mret_req),
        .irq_pending_i    (irq_pending_i),
        .irq_cause_i      (irq_cause_i),
        .trap_vector_i    (trap_vector_i),
        .epc_i            (epc_i),
        .trap_entry_o     (trap_entry_o),
        .trap_return_o    (trap_return_o),
        .trap_pc_o        (trap_pc_o),
        .trap_cause_o     (trap_cause_o),
        .trap_val_o       (trap_val_o),
        .stall_o          (stall_o),
        .flush_o          (flush_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // CSR unit environment: mtvec direct/vectored target driven from mcause.
    always_comb begin
        if (mtvec[1:0] == 2'b01 && trap_cause_o[31])
            trap_vector_i = {mtvec[31:2], 2'b00} + {trap_cause_o[29:0], 2'b00};
        else
            trap_vector_i = {mtvec[31:2], 2'b00};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] vector_of(input logic [31:0] mtv, input logic [31:0] cause);
        logic [31:0] base;
        base = mtv & 32'hFFFF_FFFC;
        if (mtv[1:0] == 2'b01 && cause[31]) return base + 32'd4 * (cause & 32'h7FFF_FFFF);
        return base;
    endfunction

    function automatic exp_t predict(input logic [31:0] pc, input logic [5:0] exc,
                                     input logic [31:0] tval, input logic irq,
                                     input logic [31:0] icause, input logic [31:0] mtv,
                                     input logic [31:0] epc);
        exp_t it;
        bit   found;
        it.kind = K_ENTRY; it.cyc = 0; it.pc = pc; it.cause = '0; it.val = '0; it.redir = '0;
        found = 1'b0;
        if (irq) begin
            it.cause = icause;
        end else if (exc != 6'd0) begin
            for (int k = 0; k < 6; k++) begin
                if (!found && exc[k]) begin
                    found    = 1'b1;
                    it.cause = EXC_CAUSE[k];
                    it.val   = EXC_HAS_TVAL[k] ? tval : 32'd0;
                end
            end
        end else begin
            it.kind  = K_RETURN;
            it.redir = epc;
            return it;
        end
        it.redir = vector_of(mtv, it.cause);
        return it;
    endfunction

    // One cycle of stimulus, applied just after the rising edge.
    task automatic step(input logic b, input logic [31:0] pc, input logic [5:0] exc,
                        input logic [31:0] tval, input logic mret, input logic irq,
                        input logic [31:0] icause, input logic [31:0] mtv, input logic [31:0] epc);
        bit   act;
        exp_t it;
        @(posedge clk);
        #2;
        instr_boundary = b;   cur_pc = pc;   exc_req = exc; exc_tval = tval;
        mret_req = mret;      irq_pending_i = irq; irq_cause_i = icause;
        // The CSR values only move while no sequence is in flight.
        if (cyc > busy_until) begin
            mtvec = mtv;
            epc_i = epc;
        end
        act = b && (cyc > busy_until) && (irq || exc != 6'd0 || mret);
        if (act) begin
            it = predict(pc, exc, tval, irq, icause, mtv, epc);
            it.cyc = cyc;
            sb.push_back(it);
            last_accept = cyc;
            busy_until  = cyc + ((it.kind == K_ENTRY) ? 2 : 1);
        end
        #1 check("flush", 32'(flush_o), 32'(act));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, mtvec, epc_i);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_entry"}, 32'(trap_entry_o), 32'd0);
        check({tag, "_return"}, 32'(trap_return_o), 32'd0);
        check({tag, "_stall"}, 32'(stall_o), 32'd0);
        check({tag, "_redir_v"}, 32'(redirect_valid_o), 32'd0);
        check({tag, "_redir_pc"}, redirect_pc_o, 32'd0);
        check({tag, "_pc"}, trap_pc_o, 32'd0);
        check({tag, "_cause"}, trap_cause_o, 32'd0);
        check({tag, "_val"}, trap_val_o, 32'd0);
    endtask

    // Monitor: compare DUT pulses against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            check("stall", 32'(stall_o), 32'((cyc > last_accept) && (cyc <= busy_until)));
            if (trap_entry_o) begin
                check("entry_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    mon_it = sb.pop_front();
                    check("entry_kind", 32'(mon_it.kind == K_ENTRY), 32'd1);
                    check("entry_cycle", 32'(cyc), 32'(mon_it.cyc + 1));
                    check("entry_pc", trap_pc_o, mon_it.pc);
                    check("entry_cause", trap_cause_o, mon_it.cause);
                    check("entry_val", trap_val_o, mon_it.val);
                    pend       = mon_it;
                    pend_valid = 1'b1;
                end
            end
            if (trap_return_o) begin
                check("return_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    mon_it = sb.pop_front();
                    check("return_kind", 32'(mon_it.kind == K_RETURN), 32'd1);
                    check("return_cycle", 32'(cyc), 32'(mon_it.cyc + 1));
                    check("return_redir_v", 32'(redirect_valid_o), 32'd1);
                    check("return_redir_pc", redirect_pc_o, mon_it.redir);
                end
            end else if (redirect_valid_o) begin
                check("redirect_expected", 32'(pend_valid), 32'd1);
                if (pend_valid) begin
                    check("redirect_cycle", 32'(cyc), 32'(pend.cyc + 2));
                    check("redirect_pc", redirect_pc_o, pend.redir);
                    check("redirect_cause_held", trap_cause_o, pend.cause);
                    pend_valid = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [5:0]  r_exc;
        logic [31:0] r_mtv;

        // Reset state.
        repeat (2) @(posedge clk);
        #3 check_all_zero("reset");
        check("reset_flush", 32'(flush_o), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Illegal instruction, direct mtvec.
        step(1'b1, 32'h100, 6'b000010, 32'h0000_FFFF, 1'b0, 1'b0, '0, 32'h200, '0);
        idle(3);
        // Interrupt wins over a coincident ecall; vectored mtvec.
        step(1'b1, 32'h40, 6'b001000, 32'h1234_5678, 1'b0, 1'b1, 32'h8000_000B, 32'h201, '0);
        idle(3);
        // MRET.
        step(1'b1, 32'h220, 6'b000000, '0, 1'b1, 1'b0, '0, 32'h201, 32'h104);
        idle(2);
        // ecall + ld_misalign + st_misalign: ecall wins, tval zero.
        step(1'b1, 32'h300, 6'b111000, 32'hCAFE_F00D, 1'b0, 1'b0, '0, 32'h400, '0);
        // Exceptions presented while stalled must be ignored.
        step(1'b1, 32'h304, 6'b000001, 32'h1111_1111, 1'b0, 1'b0, '0, 32'h400, '0);
        step(1'b1, 32'h308, 6'b000010, 32'h2222_2222, 1'b0, 1'b0, '0, 32'h400, '0);
        idle(1);
        // ebreak + ld + st: ebreak wins.
        step(1'b1, 32'h500, 6'b110100, 32'hFFFF_0000, 1'b0, 1'b0, '0, 32'h600, '0);
        idle(3);
        // Back-to-back: trap then an ebreak boundary at N+3.
        step(1'b1, 32'h700, 6'b010000, 32'h0000_0703, 1'b0, 1'b0, '0, 32'h800, '0);
        idle(2);
        step(1'b1, 32'h704, 6'b000100, 32'hABCD_0000, 1'b0, 1'b0, '0, 32'h800, '0);
        idle(3);

        // Reset while in ENTER aborts the sequence with no pulse.
        step(1'b1, 32'h900, 6'b000010, 32'h0000_DEAD, 1'b0, 1'b0, '0, 32'h200, '0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        instr_boundary = 1'b0; exc_req = '0; mret_req = 1'b0; irq_pending_i = 1'b0;
        sb.delete();
        pend_valid  = 1'b0;
        busy_until  = -1;
        last_accept = -1;
        #1 check_all_zero("rst_mid");
        @(posedge clk);
        #2 rst_n = 1'b1;
        step(1'b1, 32'hA00, 6'b000000, 32'h5555_5555, 1'b0, 1'b0, '0, 32'h200, '0);
        idle(4);

        // Randomized traffic; requests during busy cycles are ignored by the model too.
        for (int i = 0; i < 400; i++) begin
            r_exc = ($urandom_range(0, 2) == 0) ? (6'($urandom) & 6'($urandom)) : 6'd0;
            r_mtv = ($urandom & 32'h0000_FFFC) | 32'($urandom_range(0, 1));
            step(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, r_exc, $urandom,
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0),
                 32'h8000_0000 | 32'($urandom_range(0, 15)), r_mtv, $urandom & 32'hFFFF_FFFC);
        end

        // Drain: every predicted event must have been observed.
        idle(3);
        for (int i = 0; i < 20 && (sb.size() != 0 || pend_valid); i++) idle(1);
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("redirect_drained", 32'(pend_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
